// File: rtl/sudoku_input_ctrl_pkg.sv
// Shared constants, state/action encodings and cursor wrap helpers for the
// Sudoku input controller.
package sudoku_input_ctrl_pkg;

    localparam int GRID_N   = 9;
    localparam int GRID_MAX = GRID_N - 1;
    localparam int DIGIT_W  = 4;

    typedef enum logic {
        ST_IDLE,
        ST_WRITE
    } state_e;

    typedef enum logic [2:0] {
        ACT_NONE,
        ACT_UP,
        ACT_DOWN,
        ACT_LEFT,
        ACT_RIGHT,
        ACT_INC,
        ACT_CLR,
        ACT_GO
    } action_e;

    // Step a cursor coordinate forward, 8 -> 0.
    function automatic logic [DIGIT_W-1:0] wrap_inc(input logic [DIGIT_W-1:0] v);
        return (v >= DIGIT_W'(GRID_MAX)) ? '0 : v + DIGIT_W'(1);
    endfunction

    // Step a cursor coordinate backward, 0 -> 8.
    function automatic logic [DIGIT_W-1:0] wrap_dec(input logic [DIGIT_W-1:0] v);
        return (v == '0) ? DIGIT_W'(GRID_MAX) : v - DIGIT_W'(1);
    endfunction

endpackage

// File: rtl/sudoku_input_ctrl_btn_repeat.sv
// Rising-edge detection plus hold-to-repeat for the five repeatable buttons.
// Bit order: 0 up, 1 down, 2 left, 3 right, 4 inc. Only the highest-priority
// held button (inc > up > down > left > right) is tracked for auto-repeat.
module sudoku_input_ctrl_btn_repeat #(
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 5000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] btn_i,
    output logic [4:0] pulse_o
);

    localparam int MAX_CNT = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam logic [CNT_W-1:0] DELAY_END = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_END  = CNT_W'(REPEAT_RATE - 1);
    localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(MAX_CNT);

    logic [4:0]       prev_q;
    logic [4:0]       track_d, track_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             first_done_d, first_done_q;
    logic [4:0]       pulse_d, pulse_q;
    logic             restart, fire;

    // Select the tracked button and decide when the repeat counter fires.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        track_d = '0;
        if      (btn_i[4]) track_d = 5'b10000;
        else if (btn_i[0]) track_d = 5'b00001;
        else if (btn_i[1]) track_d = 5'b00010;
        else if (btn_i[2]) track_d = 5'b00100;
        else if (btn_i[3]) track_d = 5'b01000;

        restart = (track_d != track_q) || (track_d == '0);
        fire    = !restart && (cnt_q == (first_done_q ? RATE_END : DELAY_END));

        cnt_d        = cnt_q;
        first_done_d = first_done_q;
        if (restart || fire) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_SAT) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (restart)   first_done_d = 1'b0;
        else if (fire) first_done_d = 1'b1;

        pulse_d = (btn_i & ~prev_q) | (fire ? track_q : 5'b00000);
    end

    // Button history, tracking state, repeat counter and registered pulses.
    // NOTE: history resets to 1 so a button held through reset release is
    // not seen as a fresh press; state is updated with non-blocking
    // assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q       <= '1;
            track_q      <= '0;
            cnt_q        <= '0;
            first_done_q <= 1'b0;
            pulse_q      <= '0;
        end else begin
            prev_q       <= btn_i;
            track_q      <= track_d;
            cnt_q        <= cnt_d;
            first_done_q <= first_done_d;
            pulse_q      <= pulse_d;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/sudoku_input_ctrl.sv
// Turns debounced button levels into cursor moves, single-cell grid writes
// over a valid/ready handshake, and one-cycle solve requests.
module sudoku_input_ctrl
    import sudoku_input_ctrl_pkg::*;
#(
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 5000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic               btn_inc,
    input  logic               btn_clr,
    input  logic               btn_go,
    input  logic               edit_en,
    input  logic [DIGIT_W-1:0] cell_digit,
    output logic [DIGIT_W-1:0] cur_row,
    output logic [DIGIT_W-1:0] cur_col,
    output logic               wr_valid,
    output logic [DIGIT_W-1:0] wr_row,
    output logic [DIGIT_W-1:0] wr_col,
    output logic [DIGIT_W-1:0] wr_digit,
    input  logic               wr_ready,
    output logic               solve_start
);

    logic [4:0]         rep_pulse;
    logic [1:0]         cg_prev_q;
    logic               clr_ev_q, go_ev_q;
    action_e            action;
    logic [DIGIT_W-1:0] inc_digit;

    state_e             state_q;
    logic [DIGIT_W-1:0] cur_row_q, cur_col_q;
    logic               wr_valid_q, solve_start_q;
    logic [DIGIT_W-1:0] wr_row_q, wr_col_q, wr_digit_q;

    sudoku_input_ctrl_btn_repeat #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) u_btn_repeat (
        .clk     (clk),
        .reset   (reset),
        .btn_i   ({btn_inc, btn_right, btn_left, btn_down, btn_up}),
        .pulse_o (rep_pulse)
    );

    // Edge-only detection for clear and go; neither auto-repeats.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cg_prev_q <= '1;
            clr_ev_q  <= 1'b0;
            go_ev_q   <= 1'b0;
        end else begin
            cg_prev_q <= {btn_go, btn_clr};
            clr_ev_q  <= btn_clr & ~cg_prev_q[0];
            go_ev_q   <= btn_go  & ~cg_prev_q[1];
        end
    end

    // Pick the single winning action this cycle and the digit an inc would write.
    always_comb begin
        action = ACT_NONE;
        if      (clr_ev_q)     action = ACT_CLR;
        else if (go_ev_q)      action = ACT_GO;
        else if (rep_pulse[4]) action = ACT_INC;
        else if (rep_pulse[0]) action = ACT_UP;
        else if (rep_pulse[1]) action = ACT_DOWN;
        else if (rep_pulse[2]) action = ACT_LEFT;
        else if (rep_pulse[3]) action = ACT_RIGHT;

        inc_digit = (cell_digit >= DIGIT_W'(9)) ? '0 : cell_digit + DIGIT_W'(1);
    end

    // Editing FSM: cursor moves, write launch/handshake and solve pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cur_row_q     <= '0;
            cur_col_q     <= '0;
            wr_valid_q    <= 1'b0;
            wr_row_q      <= '0;
            wr_col_q      <= '0;
            wr_digit_q    <= '0;
            solve_start_q <= 1'b0;
        end else begin
            solve_start_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (edit_en) begin
                        case (action)
                            ACT_UP:    cur_row_q <= wrap_dec(cur_row_q);
                            ACT_DOWN:  cur_row_q <= wrap_inc(cur_row_q);
                            ACT_LEFT:  cur_col_q <= wrap_dec(cur_col_q);
                            ACT_RIGHT: cur_col_q <= wrap_inc(cur_col_q);
                            ACT_GO:    solve_start_q <= 1'b1;
                            ACT_INC, ACT_CLR: begin
                                wr_row_q   <= cur_row_q;
                                wr_col_q   <= cur_col_q;
                                wr_digit_q <= (action == ACT_INC) ? inc_digit : '0;
                                wr_valid_q <= 1'b1;
                                state_q    <= ST_WRITE;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_WRITE: begin
                    if (wr_ready) begin
                        wr_valid_q <= 1'b0;
                        state_q    <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cur_row     = cur_row_q;
    assign cur_col     = cur_col_q;
    assign wr_valid    = wr_valid_q;
    assign wr_row      = wr_row_q;
    assign wr_col      = wr_col_q;
    assign wr_digit    = wr_digit_q;
    assign solve_start = solve_start_q;

endmodule

// File: tb/tb_sudoku_input_ctrl.sv
// Directed self-checking bench for sudoku_input_ctrl with short repeat timing.
module tb_sudoku_input_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] btn = '0;   // 0 up, 1 down, 2 left, 3 right, 4 inc, 5 clr, 6 go
    logic       edit_en = 1'b1;
    logic [3:0] cell_digit = '0;
    logic       wr_ready = 1'b0;
    logic [3:0] cur_row, cur_col, wr_row, wr_col, wr_digit;
    logic       wr_valid, solve_start;

    int n_cmp = 0;
    int n_bad = 0;
    int vcnt = 0;
    int scnt = 0;

    always #5 clk = ~clk;

    sudoku_input_ctrl #(
        .REPEAT_DELAY (20),
        .REPEAT_RATE  (5)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_up      (btn[0]),
        .btn_down    (btn[1]),
        .btn_left    (btn[2]),
        .btn_right   (btn[3]),
        .btn_inc     (btn[4]),
        .btn_clr     (btn[5]),
        .btn_go      (btn[6]),
        .edit_en     (edit_en),
        .cell_digit  (cell_digit),
        .cur_row     (cur_row),
        .cur_col     (cur_col),
        .wr_valid    (wr_valid),
        .wr_row      (wr_row),
        .wr_col      (wr_col),
        .wr_digit    (wr_digit),
        .wr_ready    (wr_ready),
        .solve_start (solve_start)
    );

    // Count cycles with wr_valid / solve_start high (pre-edge values).
    always @(posedge clk) begin
        if (wr_valid)    vcnt++;
        if (solve_start) scnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        btn = '0;
        @(negedge clk) reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse(input int idx);
        @(negedge clk) btn[idx] = 1'b1;
        @(negedge clk) btn[idx] = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Press the buttons in mask for one cycle, then follow the resulting write.
    // wr_ready goes high at the ready_at-th valid cycle; hi returns the number
    // of cycles wr_valid stayed high, r/c/d the fields seen on the first one.
    task automatic press_write(input logic [6:0] mask, input int ready_at, input bit inject_right,
                               output int hi, output logic [3:0] r, output logic [3:0] c,
                               output logic [3:0] d);
        bit done;
        hi = 0; done = 1'b0; r = '0; c = '0; d = '0;
        @(negedge clk) btn = btn | mask;
        @(negedge clk) btn = btn & ~mask;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (wr_valid) begin
                hi++;
                if (hi == 1) begin
                    r = wr_row; c = wr_col; d = wr_digit;
                end
                if (inject_right) btn[3] = (hi == 1);
                wr_ready = (hi >= ready_at);
            end else if (hi > 0) begin
                done = 1'b1;
            end
        end
        wr_ready = 1'b0;
        btn[3]   = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int hi, s0, v0;
        logic [3:0] r, c, d;
        bit seen;

        // Reset state
        @(negedge clk);
        check("rst_row", cur_row, 0);
        check("rst_col", cur_col, 0);
        check("rst_wr_valid", wr_valid, 0);
        check("rst_solve", solve_start, 0);
        do_reset();

        // Basic moves and wrap-around
        pulse(1); pulse(3);
        check("move_row", cur_row, 1);
        check("move_col", cur_col, 1);
        do_reset();
        pulse(0);
        check("wrap_up_row", cur_row, 8);
        pulse(2);
        check("wrap_left_col", cur_col, 8);

        // Inc on digit 9 with stalled ready; right press during write is dropped
        do_reset();
        pulse(1); pulse(1); pulse(3); pulse(3); pulse(3);
        check("pos_row", cur_row, 2);
        check("pos_col", cur_col, 3);
        cell_digit = 4'd9;
        press_write(7'b0010000, 4, 1'b1, hi, r, c, d);
        check("wr_cycles", hi, 4);
        check("wr_row", r, 2);
        check("wr_col", c, 3);
        check("wr_digit_9", d, 0);
        check("drop_row", cur_row, 2);
        check("drop_col", cur_col, 3);
        cell_digit = 4'd4;
        press_write(7'b0010000, 1, 1'b0, hi, r, c, d);
        check("wr_digit_4", d, 5);
        cell_digit = 4'd12;
        press_write(7'b0010000, 1, 1'b0, hi, r, c, d);
        check("wr_digit_12", d, 0);

        // Hold down for 40 cycles: edge + repeats at 20, 25, 30, 35
        do_reset();
        @(negedge clk) btn[1] = 1'b1;
        repeat (40) @(negedge clk);
        btn[1] = 1'b0;
        repeat (5) @(negedge clk);
        check("hold_row", cur_row, 5);
        check("hold_col", cur_col, 0);

        // Clear and up together: clear wins, up dropped
        cell_digit = 4'd7;
        press_write(7'b0100001, 1, 1'b0, hi, r, c, d);
        check("clr_cycles", hi, 1);
        check("clr_digit", d, 0);
        check("clr_row", r, 5);
        check("clr_col", c, 0);
        check("clr_cur_row", cur_row, 5);

        // Editing disabled: everything ignored
        edit_en = 1'b0;
        s0 = scnt; v0 = vcnt;
        pulse(6); pulse(4); pulse(0);
        check("dis_solve", scnt - s0, 0);
        check("dis_write", vcnt - v0, 0);
        check("dis_row", cur_row, 5);
        edit_en = 1'b1;
        s0 = scnt;
        pulse(6);
        check("go_pulse_len", scnt - s0, 1);
        check("go_no_write", vcnt - v0, 0);

        // Inc held through reset release produces no write
        @(negedge clk) reset = 1'b1; btn[4] = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        v0 = vcnt;
        repeat (10) @(negedge clk);
        check("held_rst_write", vcnt - v0, 0);
        btn[4] = 1'b0;
        repeat (3) @(negedge clk);

        // Reset during WRITE drops wr_valid at once
        pulse(1); pulse(1); pulse(3);
        cell_digit = 4'd3;
        wr_ready = 1'b0;
        @(negedge clk) btn[4] = 1'b1;
        @(negedge clk) btn[4] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (wr_valid) seen = 1'b1;
        end
        check("pre_rst_valid", seen, 1);
        check("pre_rst_row", cur_row, 2);
        reset = 1'b1;
        #1;
        check("rst_mid_valid", wr_valid, 0);
        check("rst_mid_row", cur_row, 0);
        check("rst_mid_col", cur_col, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
